led_pwm_fader: RTL

LED_PWM_FADER -- requirements
Module: led_pwm_fader

---
 rtl/led_pwm_fader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: four-channel LED brightness fader.
// Each channel ramps an 8-bit brightness toward full-on or full-off,
// following the registered led_in pattern, and drives its pin with a
// 256-step PWM derived from a shared free-running counter.
module led_pwm_fader #(
    parameter int PWM_DIV        = 4,
    parameter int FADE_DIV       = 195313,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] led_in,
    input  logic       en,
    output logic [3:0] led_out,
    output logic       busy
);

    // PWM_DIV = 1 still needs a one-bit prescaler; it simply never leaves 0.
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int FW = $clog2(FADE_DIV);

    localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_DIV - 1);
    localparam logic [PW-1:0] PWM_ONE   = PW'(1);
    localparam logic [FW-1:0] FADE_LAST = FW'(FADE_DIV - 1);
    localparam logic [FW-1:0] FADE_ONE  = FW'(1);
    localparam logic [3:0]    OFF_LEVEL = {4{LED_ACTIVE_LOW}};

    logic [3:0]    tgt;
    logic [PW-1:0] pwm_pre;
    logic          pwm_tick;
    logic [7:0]    pwm_cnt;
    logic [FW-1:0] fade_pre;
    logic          fade_tick;
    logic [7:0]    bri [4];
    logic [3:0]    lit;
    logic          busy_d;

    assign pwm_tick  = (pwm_pre == PWM_LAST);
    assign fade_tick = (fade_pre == FADE_LAST);

    // Target pattern: one register stage, no filtering, so even a
    // single-cycle pulse on led_in becomes a one-cycle target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt <= 4'b0000;
        end else begin
            tgt <= led_in;
        end
    end

    // PWM prescaler and the shared 8-bit PWM phase counter (wraps 255 -> 0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_pre <= '0;
            pwm_cnt <= 8'd0;
        end else begin
            if (pwm_tick) begin
                pwm_pre <= '0;
                pwm_cnt <= pwm_cnt + 8'd1;
            end else begin
                pwm_pre <= pwm_pre + PWM_ONE;
            end
        end
    end

    // Fade prescaler, independent of the PWM timebase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fade_pre <= '0;
        end else if (fade_tick) begin
            fade_pre <= '0;
        end else begin
            fade_pre <= fade_pre + FADE_ONE;
        end
    end

    // Brightness: one saturating step toward the current target per fade tick.
    // Uses the registered tgt, so a led_in change on a tick edge only counts
    // from the following tick; a reversal continues from the present value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                bri[i] <= 8'd0;
            end
        end else if (fade_tick) begin
            for (int i = 0; i < 4; i++) begin
                if (tgt[i] && (bri[i] != 8'hFF)) begin
                    bri[i] <= bri[i] + 8'd1;
                end else if (!tgt[i] && (bri[i] != 8'h00)) begin
                    bri[i] <= bri[i] - 8'd1;
                end
            end
        end
    end

    // Raw lit state and settle detection. bri = 255 is forced on so that
    // full brightness has no dark slot when pwm_cnt reaches 255.
    always_comb begin
        lit    = 4'b0000;
        busy_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lit[i] = (bri[i] == 8'hFF) || (bri[i] > pwm_cnt);
            if (bri[i] != (tgt[i] ? 8'hFF : 8'h00)) begin
                busy_d = 1'b1;
            end
        end
    end

    // Output registers: enable gating, then pin polarity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_out <= OFF_LEVEL;
            busy    <= 1'b0;
        end else begin
            led_out <= (lit & {4{en}}) ^ OFF_LEVEL;
            busy    <= busy_d;
        end
    end

endmodule
